// File: rtl/button_debouncer_pkg.sv
// Shared definitions for the button debouncer: FSM state encodings and default parameters.
package button_debouncer_pkg;

    typedef enum logic [1:0] {
        ST_STABLE_LOW  = 2'd0,
        ST_WAIT_HIGH   = 2'd1,
        ST_STABLE_HIGH = 2'd2,
        ST_WAIT_LOW    = 2'd3
    } state_t;

    // 20 ms at 50 MHz
    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 1000000;
    localparam int unsigned DEFAULT_SYNC_STAGES     = 2;

endpackage

// File: rtl/button_debouncer_if.sv
// Button-side signal bundle: raw level in, debounced level and busy flag out.
interface button_debouncer_if;

    logic in;
    logic out;
    logic busy;

    modport master (output in, input out, input busy);
    modport slave  (input in, output out, output busy);

endinterface

// File: rtl/sync_chain.sv
// Reset-to-zero flip-flop synchronizer for an asynchronous single-bit input.
module sync_chain #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic async_reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] r_sync;

    always_ff @(posedge clk or posedge async_reset) begin
        if (async_reset) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], d};
        end
    end

    assign q = r_sync[STAGES-1];

endmodule

// File: rtl/button_debouncer.sv
// Synchronizes a raw button input, then passes a level only after it has held
// steady for DEBOUNCE_CYCLES clocks.
module button_debouncer
    import button_debouncer_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = DEFAULT_SYNC_STAGES,
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input logic               clk,
    input logic               async_reset,
    button_debouncer_if.slave bus
);

    localparam int unsigned CNT_WIDTH = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    logic                 w_sync_in;
    state_t               r_state;
    state_t               w_state_nxt;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic [CNT_WIDTH-1:0] w_cnt_nxt;
    logic                 r_out;
    logic                 w_out_nxt;

    sync_chain #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk         (clk),
        .async_reset (async_reset),
        .d           (bus.in),
        .q           (w_sync_in)
    );

    // Abort is checked before terminal count so a glitch on the last cycle never commits.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_out_nxt   = r_out;
        case (r_state)
            ST_STABLE_LOW: begin
                if (w_sync_in) begin
                    w_state_nxt = ST_WAIT_HIGH;
                    w_cnt_nxt   = '0;
                end
            end
            ST_WAIT_HIGH: begin
                if (!w_sync_in) begin
                    w_state_nxt = ST_STABLE_LOW;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = ST_STABLE_HIGH;
                    w_out_nxt   = 1'b1;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_WIDTH'(1);
                end
            end
            ST_STABLE_HIGH: begin
                if (!w_sync_in) begin
                    w_state_nxt = ST_WAIT_LOW;
                    w_cnt_nxt   = '0;
                end
            end
            ST_WAIT_LOW: begin
                if (w_sync_in) begin
                    w_state_nxt = ST_STABLE_HIGH;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = ST_STABLE_LOW;
                    w_out_nxt   = 1'b0;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_WIDTH'(1);
                end
            end
            default: begin
                w_state_nxt = ST_STABLE_LOW;
                w_cnt_nxt   = '0;
                w_out_nxt   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge async_reset) begin
        if (async_reset) begin
            r_state <= ST_STABLE_LOW;
            r_cnt   <= '0;
            r_out   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_out   <= w_out_nxt;
        end
    end

    assign bus.out  = r_out;
    assign bus.busy = (r_state == ST_WAIT_HIGH) || (r_state == ST_WAIT_LOW);

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer: SYNC_STAGES=2 with DEBOUNCE_CYCLES=4 and =1.
module tb_button_debouncer;

    logic clk;
    logic async_reset;
    int   n_checks;
    int   n_errors;

    button_debouncer_if a_if ();
    button_debouncer_if b_if ();

    button_debouncer #(
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4)
    ) dut_a (
        .clk         (clk),
        .async_reset (async_reset),
        .bus         (a_if.slave)
    );

    button_debouncer #(
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (1)
    ) dut_b (
        .clk         (clk),
        .async_reset (async_reset),
        .bus         (b_if.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Bounce pattern applied before edges 1..12; expected values observed after each edge.
    logic bounce_in   [1:12] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic bounce_busy [1:12] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic bounce_out  [1:12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        async_reset = 1'b0;
        a_if.in     = 1'b0;
        b_if.in     = 1'b0;

        // 1. Asynchronous reset, observed before any clock edge
        #2 async_reset = 1'b1;
        #1;
        check("reset_out_a", a_if.out, 1'b0);
        check("reset_busy_a", a_if.busy, 1'b0);
        check("reset_out_b", b_if.out, 1'b0);
        check("reset_busy_b", b_if.busy, 1'b0);
        tick();
        tick();
        async_reset = 1'b0;
        tick();
        tick();
        check("idle_out_a", a_if.out, 1'b0);
        check("idle_busy_a", a_if.busy, 1'b0);

        // 2. Clean press
        a_if.in = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            tick();
            check($sformatf("press_busy_e%0d", e), a_if.busy, (e >= 3 && e <= 6) ? 1'b1 : 1'b0);
            check($sformatf("press_out_e%0d", e), a_if.out, (e >= 7) ? 1'b1 : 1'b0);
        end

        // 4. Release
        a_if.in = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            tick();
            check($sformatf("release_busy_e%0d", e), a_if.busy, (e >= 3 && e <= 6) ? 1'b1 : 1'b0);
            check($sformatf("release_out_e%0d", e), a_if.out, (e >= 7) ? 1'b0 : 1'b1);
        end

        // 3. Bounce before settling high
        for (int e = 1; e <= 12; e++) begin
            a_if.in = bounce_in[e];
            tick();
            check($sformatf("bounce_busy_e%0d", e), a_if.busy, bounce_busy[e]);
            check($sformatf("bounce_out_e%0d", e), a_if.out, bounce_out[e]);
        end
        a_if.in = 1'b0;
        for (int e = 1; e <= 8; e++) tick();
        check("bounce_release_out", a_if.out, 1'b0);

        // 5. Reset in the middle of WAIT_HIGH
        a_if.in = 1'b1;
        for (int e = 1; e <= 5; e++) tick();
        check("midwait_busy", a_if.busy, 1'b1);
        check("midwait_out", a_if.out, 1'b0);
        #2 async_reset = 1'b1;
        #1;
        check("midwait_rst_out", a_if.out, 1'b0);
        check("midwait_rst_busy", a_if.busy, 1'b0);
        tick();
        async_reset = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            tick();
            check($sformatf("requal_busy_e%0d", e), a_if.busy, (e >= 3 && e <= 6) ? 1'b1 : 1'b0);
            check($sformatf("requal_out_e%0d", e), a_if.out, (e >= 7) ? 1'b1 : 1'b0);
        end

        // 6. DEBOUNCE_CYCLES=1: clean press, release, then a single-cycle glitch
        b_if.in = 1'b1;
        for (int e = 1; e <= 5; e++) begin
            tick();
            check($sformatf("d1_press_busy_e%0d", e), b_if.busy, (e == 3) ? 1'b1 : 1'b0);
            check($sformatf("d1_press_out_e%0d", e), b_if.out, (e >= 4) ? 1'b1 : 1'b0);
        end
        b_if.in = 1'b0;
        for (int e = 1; e <= 6; e++) tick();
        check("d1_release_out", b_if.out, 1'b0);
        b_if.in = 1'b1;
        tick();
        check("d1_glitch_out_e1", b_if.out, 1'b0);
        b_if.in = 1'b0;
        for (int e = 2; e <= 6; e++) begin
            tick();
            check($sformatf("d1_glitch_busy_e%0d", e), b_if.busy, (e == 3) ? 1'b1 : 1'b0);
            check($sformatf("d1_glitch_out_e%0d", e), b_if.out, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
